// File: rtl/ctrl_fsm_gen.sv
// Multi-mode control FSM producing datapath enables/selects for the y and s registers.
// Regimes: off, enumerate (wait + active), count, refresh; outputs decode state, counters and live inputs.
module ctrl_fsm_gen #(
  parameter int unsigned ENUM_LEN    = 16,
  parameter int unsigned ENUM_PERIOD = 4,
  parameter int unsigned STEP_W      = 2,
  parameter int unsigned STEP_INIT   = 1,
  parameter int unsigned STEP_ALT    = 2,
  parameter int unsigned REFRESH_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        on,
  input  logic              start,
  input  logic              abort,
  input  logic              s_is_zero,
  output logic [1:0]        regime,
  output logic              active,
  output logic              busy,
  output logic              done,
  output logic [1:0]        y_select_next,
  output logic [STEP_W-1:0] s_step,
  output logic              y_en,
  output logic              s_en,
  output logic              y_store_x,
  output logic              s_add,
  output logic              s_zero
);

  localparam int unsigned EC_W = $clog2(ENUM_LEN + 1);
  localparam int unsigned RC_W = $clog2(REFRESH_LEN);
  localparam int unsigned PC_W = (ENUM_PERIOD > 1) ? $clog2(ENUM_PERIOD) : 1;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_ENUM_WAIT = 3'd1,
    ST_ENUM_ACT  = 3'd2,
    ST_COUNT     = 3'd3,
    ST_REFRESH   = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [EC_W-1:0] ec, ec_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [RC_W-1:0] rc, rc_next;

  logic ec_last;
  logic rc_last;

  assign ec_last = (ec == EC_W'(ENUM_LEN));
  assign rc_last = (rc == RC_W'(REFRESH_LEN - 1));

  // State and phase counters; pc tracks ec mod ENUM_PERIOD without a divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OFF;
      ec    <= '0;
      pc    <= '0;
      rc    <= '0;
    end else begin
      state <= state_next;
      ec    <= ec_next;
      pc    <= pc_next;
      rc    <= rc_next;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_next    = state;
    ec_next       = ec;
    pc_next       = pc;
    rc_next       = rc;
    regime        = 2'd0;
    active        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    y_select_next = 2'd0;
    s_step        = '0;
    y_en          = 1'b0;
    s_en          = 1'b0;
    y_store_x     = 1'b0;
    s_add         = 1'b0;
    s_zero        = 1'b0;

    case (state)
      ST_OFF: begin
        case (on)
          2'd1:    state_next = ST_ENUM_WAIT;
          2'd2:    state_next = ST_COUNT;
          2'd3: begin
            state_next = ST_REFRESH;
            rc_next    = '0;
          end
          default: state_next = ST_OFF;
        endcase
      end

      ST_ENUM_WAIT: begin
        regime = 2'd1;
        busy   = 1'b1;
        if (start) begin
          state_next = ST_ENUM_ACT;
          ec_next    = '0;
          pc_next    = '0;
        end
      end

      ST_ENUM_ACT: begin
        regime = 2'd1;
        busy   = 1'b1;
        active = 1'b1;
        s_add  = 1'b1;
        if (pc == '0) begin
          s_en = 1'b1;
          if ((ec == '0) || ec_last) begin
            s_zero = 1'b1;
            s_step = STEP_W'(STEP_INIT);
          end else begin
            s_step = STEP_W'(STEP_ALT);
          end
        end
        if (ec_last) begin
          done       = !abort;
          state_next = ST_OFF;
        end else begin
          ec_next = ec + EC_W'(1);
          pc_next = (pc == PC_W'(ENUM_PERIOD - 1)) ? '0 : pc + PC_W'(1);
        end
      end

      ST_COUNT: begin
        regime = 2'd2;
        busy   = 1'b1;
        if (start) begin
          s_en          = 1'b1;
          s_step        = STEP_W'(STEP_INIT);
          y_en          = s_is_zero;
          y_select_next = s_is_zero ? 2'd1 : 2'd0;
        end else begin
          state_next = ST_OFF;
        end
      end

      ST_REFRESH: begin
        regime = 2'd3;
        busy   = 1'b1;
        if (rc_last) begin
          done       = !abort;
          state_next = ST_OFF;
        end else begin
          rc_next = rc + RC_W'(1);
          y_en    = 1'b1;
          if (rc == '0) begin
            y_store_x = 1'b1;
          end else begin
            s_en          = 1'b1;
            s_add         = 1'b1;
            s_step        = STEP_W'(STEP_INIT);
            y_select_next = 2'd3;
          end
        end
      end

      default: state_next = ST_OFF;
    endcase

    // Abort wins over every other transition
    if (abort) begin
      state_next = ST_OFF;
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_gen.sv
// Self-checking bench: two parameter builds driven in lockstep and compared every cycle
// against a phase/cycle-index reference model derived from the mode rules.
module tb_ctrl_fsm_gen;

  localparam int LA = 16, PA = 4, RA = 3;
  localparam int LB = 8,  PB = 2, RB = 5;

  localparam int M_OFF = 0, M_WAIT = 1, M_ACT = 2, M_CNT = 3, M_REF = 4;

  typedef struct packed {
    logic [1:0] regime;
    logic       active;
    logic       busy;
    logic       done;
    logic [1:0] ysel;
    logic [1:0] step;
    logic       yen;
    logic       sen;
    logic       ystore;
    logic       sadd;
    logic       szero;
  } outs_t;

  logic       clk;
  logic       rst;
  logic [1:0] on;
  logic       start;
  logic       abort;
  logic       s_is_zero;

  logic [1:0] a_regime, a_ysel, a_step, b_regime, b_ysel, b_step;
  logic a_active, a_busy, a_done, a_yen, a_sen, a_ystore, a_sadd, a_szero;
  logic b_active, b_busy, b_done, b_yen, b_sen, b_ystore, b_sadd, b_szero;
  outs_t oa, ob;

  int checks = 0;
  int errors = 0;
  int mode[2];
  int idx[2];

  ctrl_fsm_gen dut_a (
    .clk(clk), .rst(rst), .on(on), .start(start), .abort(abort), .s_is_zero(s_is_zero),
    .regime(a_regime), .active(a_active), .busy(a_busy), .done(a_done),
    .y_select_next(a_ysel), .s_step(a_step), .y_en(a_yen), .s_en(a_sen),
    .y_store_x(a_ystore), .s_add(a_sadd), .s_zero(a_szero)
  );

  ctrl_fsm_gen #(.ENUM_LEN(LB), .ENUM_PERIOD(PB), .STEP_W(2), .STEP_INIT(1), .STEP_ALT(2),
                 .REFRESH_LEN(RB)) dut_b (
    .clk(clk), .rst(rst), .on(on), .start(start), .abort(abort), .s_is_zero(s_is_zero),
    .regime(b_regime), .active(b_active), .busy(b_busy), .done(b_done),
    .y_select_next(b_ysel), .s_step(b_step), .y_en(b_yen), .s_en(b_sen),
    .y_store_x(b_ystore), .s_add(b_sadd), .s_zero(b_szero)
  );

  assign oa = {a_regime, a_active, a_busy, a_done, a_ysel, a_step, a_yen, a_sen, a_ystore, a_sadd, a_szero};
  assign ob = {b_regime, b_active, b_busy, b_done, b_ysel, b_step, b_yen, b_sen, b_ystore, b_sadd, b_szero};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int elen(int i); return (i == 0) ? LA : LB; endfunction
  function automatic int eper(int i); return (i == 0) ? PA : PB; endfunction
  function automatic int rlen(int i); return (i == 0) ? RA : RB; endfunction

  // Expected outputs for build i given its current mode, index into the phase and live inputs
  function automatic outs_t model_out(int i);
    outs_t o;
    int    k;
    o = '0;
    k = idx[i];
    case (mode[i])
      M_WAIT: begin o.regime = 2'd1; o.busy = 1'b1; end
      M_ACT: begin
        o.regime = 2'd1; o.busy = 1'b1; o.active = 1'b1; o.sadd = 1'b1;
        if (k % eper(i) == 0) begin
          o.sen = 1'b1;
          if (k == 0 || k == elen(i)) begin o.szero = 1'b1; o.step = 2'd1; end
          else o.step = 2'd2;
        end
        if (k == elen(i)) o.done = !abort;
      end
      M_CNT: begin
        o.regime = 2'd2; o.busy = 1'b1;
        if (start) begin
          o.sen = 1'b1; o.step = 2'd1; o.yen = s_is_zero;
          o.ysel = s_is_zero ? 2'd1 : 2'd0;
        end
      end
      M_REF: begin
        o.regime = 2'd3; o.busy = 1'b1;
        if (k == 0) begin o.yen = 1'b1; o.ystore = 1'b1; end
        else if (k < rlen(i) - 1) begin
          o.yen = 1'b1; o.sen = 1'b1; o.sadd = 1'b1; o.step = 2'd1; o.ysel = 2'd3;
        end else o.done = !abort;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Advance both reference models across one rising edge using the held inputs
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst || abort) mode[i] = M_OFF;
      else begin
        case (mode[i])
          M_OFF: begin
            if (on == 2'd1) mode[i] = M_WAIT;
            else if (on == 2'd2) mode[i] = M_CNT;
            else if (on == 2'd3) begin mode[i] = M_REF; idx[i] = 0; end
          end
          M_WAIT: if (start) begin mode[i] = M_ACT; idx[i] = 0; end
          M_ACT:  if (idx[i] == elen(i)) mode[i] = M_OFF; else idx[i]++;
          M_CNT:  if (!start) mode[i] = M_OFF;
          M_REF:  if (idx[i] == rlen(i) - 1) mode[i] = M_OFF; else idx[i]++;
          default: mode[i] = M_OFF;
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; on = 2'd0; start = 1'b0; abort = 1'b0; s_is_zero = 1'b0;
    mode[0] = M_OFF; mode[1] = M_OFF; idx[0] = 0; idx[1] = 0;
    #3;
    checks += 2;
    if (oa !== '0) begin errors++; $display("FAIL reset_a got=%h exp=0", oa); end
    if (ob !== '0) begin errors++; $display("FAIL reset_b got=%h exp=0", ob); end
    tick();
    tick();
    rst = 1'b0;
    #3;
    checks += 2;
    if (oa !== model_out(0)) begin errors++; $display("FAIL reset_rel_a got=%h exp=%h", oa, model_out(0)); end
    if (ob !== model_out(1)) begin errors++; $display("FAIL reset_rel_b got=%h exp=%h", ob, model_out(1)); end
    tick();
  endtask

  task automatic test_enum();
    int sen_a = 0, sen_b = 0, done_a = 0, done_b = 0;
    for (int c = 0; c < 21; c++) begin
      on = (c == 0) ? 2'd1 : 2'd0; start = (c == 1); abort = 1'b0; s_is_zero = 1'($urandom_range(0, 1));
      #3;
      checks += 2;
      if (oa !== model_out(0)) begin errors++; $display("FAIL enum_a c=%0d got=%h exp=%h", c, oa, model_out(0)); end
      if (ob !== model_out(1)) begin errors++; $display("FAIL enum_b c=%0d got=%h exp=%h", c, ob, model_out(1)); end
      sen_a += int'(oa.sen); sen_b += int'(ob.sen); done_a += int'(oa.done); done_b += int'(ob.done);
      tick();
    end
    checks += 4;
    if (sen_a !== 5) begin errors++; $display("FAIL enum_sen_a got=%0d exp=5", sen_a); end
    if (sen_b !== 5) begin errors++; $display("FAIL enum_sen_b got=%0d exp=5", sen_b); end
    if (done_a !== 1) begin errors++; $display("FAIL enum_done_a got=%0d exp=1", done_a); end
    if (done_b !== 1) begin errors++; $display("FAIL enum_done_b got=%0d exp=1", done_b); end
  endtask

  task automatic test_count();
    int yen_a = 0, sen_a = 0, done_a = 0;
    for (int c = 0; c < 8; c++) begin
      on = (c == 0) ? 2'd2 : 2'd0; start = (c >= 1 && c <= 5); abort = 1'b0; s_is_zero = (c == 3);
      #3;
      checks += 2;
      if (oa !== model_out(0)) begin errors++; $display("FAIL count_a c=%0d got=%h exp=%h", c, oa, model_out(0)); end
      if (ob !== model_out(1)) begin errors++; $display("FAIL count_b c=%0d got=%h exp=%h", c, ob, model_out(1)); end
      yen_a += int'(oa.yen); sen_a += int'(oa.sen); done_a += int'(oa.done);
      tick();
    end
    checks += 3;
    if (yen_a !== 1) begin errors++; $display("FAIL count_yen got=%0d exp=1", yen_a); end
    if (sen_a !== 5) begin errors++; $display("FAIL count_sen got=%0d exp=5", sen_a); end
    if (done_a !== 0) begin errors++; $display("FAIL count_done got=%0d exp=0", done_a); end
  endtask

  task automatic test_refresh();
    int sen_a = 0, sen_b = 0, done_a = 0, done_b = 0;
    for (int c = 0; c < 8; c++) begin
      on = (c == 0) ? 2'd3 : 2'd0; start = 1'($urandom_range(0, 1)); abort = 1'b0; s_is_zero = 1'($urandom_range(0, 1));
      #3;
      checks += 2;
      if (oa !== model_out(0)) begin errors++; $display("FAIL refresh_a c=%0d got=%h exp=%h", c, oa, model_out(0)); end
      if (ob !== model_out(1)) begin errors++; $display("FAIL refresh_b c=%0d got=%h exp=%h", c, ob, model_out(1)); end
      sen_a += int'(oa.sen); sen_b += int'(ob.sen); done_a += int'(oa.done); done_b += int'(ob.done);
      tick();
    end
    checks += 4;
    if (sen_a !== 1) begin errors++; $display("FAIL refresh_sen_a got=%0d exp=1", sen_a); end
    if (sen_b !== 3) begin errors++; $display("FAIL refresh_sen_b got=%0d exp=3", sen_b); end
    if (done_a !== 1) begin errors++; $display("FAIL refresh_done_a got=%0d exp=1", done_a); end
    if (done_b !== 1) begin errors++; $display("FAIL refresh_done_b got=%0d exp=1", done_b); end
  endtask

  task automatic test_abort();
    int done_a = 0, done_b = 0;
    // abort lands on ec=6 (cycle 8), then a fresh enumerate runs to completion
    for (int c = 0; c < 32; c++) begin
      on = (c == 0 || c == 11) ? 2'd1 : 2'd0; start = (c == 1 || c == 12); abort = (c == 8);
      s_is_zero = 1'($urandom_range(0, 1));
      #3;
      checks += 2;
      if (oa !== model_out(0)) begin errors++; $display("FAIL abort_a c=%0d got=%h exp=%h", c, oa, model_out(0)); end
      if (ob !== model_out(1)) begin errors++; $display("FAIL abort_b c=%0d got=%h exp=%h", c, ob, model_out(1)); end
      if (c == 9) begin
        checks += 1;
        if (oa !== '0) begin errors++; $display("FAIL abort_off got=%h exp=0", oa); end
      end
      if (c < 11) begin done_a += int'(oa.done); done_b += int'(ob.done); end
      tick();
    end
    checks += 2;
    if (done_a !== 0) begin errors++; $display("FAIL abort_done_a got=%0d exp=0", done_a); end
    if (done_b !== 0) begin errors++; $display("FAIL abort_done_b got=%0d exp=0", done_b); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      on = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 31) == 0);
      s_is_zero = 1'($urandom_range(0, 1));
      #3;
      checks += 2;
      if (oa !== model_out(0)) begin errors++; $display("FAIL random_a c=%0d got=%h exp=%h", c, oa, model_out(0)); end
      if (ob !== model_out(1)) begin errors++; $display("FAIL random_b c=%0d got=%h exp=%h", c, ob, model_out(1)); end
      tick();
    end
    abort = 1'b1; start = 1'b0; on = 2'd0;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    on = 2'd3; start = 1'b0; abort = 1'b0; s_is_zero = 1'b0;
    tick();
    on = 2'd0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks += 2;
    if (oa !== '0) begin errors++; $display("FAIL async_rst_a got=%h exp=0", oa); end
    if (ob !== '0) begin errors++; $display("FAIL async_rst_b got=%h exp=0", ob); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3;
      checks += 2;
      if (oa !== model_out(0)) begin errors++; $display("FAIL post_rst_a c=%0d got=%h exp=%h", c, oa, model_out(0)); end
      if (ob !== model_out(1)) begin errors++; $display("FAIL post_rst_b c=%0d got=%h exp=%h", c, ob, model_out(1)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_enum();
    test_count();
    test_refresh();
    test_abort();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
